// File: rtl/max_pool_stream.sv
// Streaming 2x2 stride-2 max pooling over a raster-order feature map.
// Define MAXPOOL_FUSED_RELU_EN to clamp negative input samples to zero before pooling.
module max_pool_stream #(
  parameter int IN_WIDTH  = 30,
  parameter int IN_HEIGHT = 30,
  parameter int DATA_W    = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int COL_W        = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int ROW_W        = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int LB_DEPTH     = (IN_WIDTH / 2 > 0) ? IN_WIDTH / 2 : 1;
  localparam int LB_AW        = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int LAST_OUT_COL = 2 * (IN_WIDTH / 2) - 1;
  localparam int LAST_OUT_ROW = 2 * (IN_HEIGHT / 2) - 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                     state_q, state_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic signed [DATA_W-1:0]   hold_q, hold_d;
  logic                       busy_q, busy_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;
  logic                       out_last_q, out_last_d;
  logic                       frame_done_q, frame_done_d;

  logic signed [DATA_W-1:0]   linebuf_q [LB_DEPTH];
  logic [LB_AW-1:0]           lb_idx;
  logic                       lb_we;
  logic signed [DATA_W-1:0]   lb_rd;
  logic signed [DATA_W-1:0]   in_sample;
  logic signed [DATA_W-1:0]   pair;
  logic signed [DATA_W-1:0]   result;

`ifdef MAXPOOL_FUSED_RELU_EN
  assign in_sample = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign in_sample = in_data;
`endif

  assign lb_idx = LB_AW'(col_q >> 1);
  assign lb_rd  = linebuf_q[lb_idx];
  // Ties keep the earlier operand: held sample over new one, buffered row over current pair.
  assign pair   = (hold_q >= in_sample) ? hold_q : in_sample;
  assign result = (lb_rd >= pair) ? lb_rd : pair;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    busy_d       = busy_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    out_data_d   = out_data_q;
    frame_done_d = out_last_q;
    lb_we        = 1'b0;

    if (frame_start) begin
      state_d = ACTIVE;
      busy_d  = 1'b1;
      col_d   = '0;
      row_d   = '0;
    end else if (state_q == ACTIVE && in_valid) begin
      if (!col_q[0]) begin
        hold_d = in_sample;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = result;
        out_last_d  = (row_q == ROW_W'(LAST_OUT_ROW)) && (col_q == COL_W'(LAST_OUT_COL));
      end

      if (col_q == COL_W'(IN_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == ROW_W'(IN_HEIGHT - 1)) begin
          row_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer has no reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[lb_idx] <= pair;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: table of full frames plus abort and mid-frame reset sequences.
// Honours MAXPOOL_FUSED_RELU_EN when computing expected values for negative inputs.
module tb_max_pool_stream;

  localparam int W      = 30;
  localparam int H      = 30;
  localparam int DATA_W = 22;
  localparam int OUT_W  = W / 2;
`ifdef MAXPOOL_FUSED_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic                     clk;
  logic                     rst;
  logic                     frame_start;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     frame_done;
  logic                     busy;

  max_pool_stream #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Stimulus pattern selected for the monitor's reference model.
  int cur_mode;
  int cur_val;
  int exp_total;
  int mon_cnt;
  bit mon_en;
  bit done_next;
  logic signed [63:0] last_data;
  int lat_q[$];

  typedef struct {
    int mode;
    int val;
    int gap;
    int exp_count;
    int exp_last;
  } vec_t;

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int sampleVal(input int mode, input int val, input int r, input int c);
    case (mode)
      0:       return r * W + c;
      1:       return val;
      2:       return -(r * W + c) - 1;
      default: return ((r + c) % 2 == 1) ? -(r * W + c) : (r * W + c);
    endcase
  endfunction

  function automatic int expVal(input int mode, input int val, input int k);
    int y;
    int x;
    y = k / OUT_W;
    x = k % OUT_W;
    case (mode)
      1:       return (RELU && val < 0) ? 0 : val;
      2:       return RELU ? 0 : -(2 * y * W + 2 * x) - 1;
      default: return (2 * y + 1) * W + 2 * x + 1;
    endcase
  endfunction

  // Checks every output against the reference sequence, its latency, and the frame_done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("frame_done", frame_done, done_next);
      done_next = 1'b0;
      if (out_valid) begin
        if (mon_cnt < exp_total) begin
          checkOutput($sformatf("out_data[%0d]", mon_cnt), out_data, expVal(cur_mode, cur_val, mon_cnt));
          checkOutput($sformatf("out_last[%0d]", mon_cnt), out_last, mon_cnt == exp_total - 1);
          if (lat_q.size() > 0)
            checkOutput($sformatf("latency[%0d]", mon_cnt), cyc, lat_q.pop_front());
          else
            checkOutput($sformatf("latency[%0d] unexpected", mon_cnt), cyc, -1);
          done_next = (mon_cnt == exp_total - 1);
        end else begin
          checkOutput("extra out_valid count", mon_cnt + 1, exp_total);
        end
        last_data = out_data;
        mon_cnt++;
      end
    end
  end

  task automatic pulseFrameStart(input bit with_valid);
    frame_start = 1'b1;
    in_valid    = with_valid;
    in_data     = DATA_W'(12345);
    @(posedge clk); #1;
    frame_start = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input int mode, input int val, input int gap,
                               input bit track);
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      r = (i / W) % H;
      c = i % W;
      in_valid = 1'b1;
      in_data  = DATA_W'(sampleVal(mode, val, r, c));
      if (track && (r % 2 == 1) && (c % 2 == 1)) lat_q.push_back(cyc + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic startMonitor(input int mode, input int val, input int expected);
    cur_mode  = mode;
    cur_val   = val;
    exp_total = expected;
    mon_cnt   = 0;
    done_next = 1'b0;
    lat_q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{mode: 0, val: 0,        gap: 0, exp_count: 225, exp_last: 899};
    vecs[1] = '{mode: 0, val: 0,        gap: 1, exp_count: 225, exp_last: 899};
    vecs[2] = '{mode: 1, val: 5,        gap: 0, exp_count: 225, exp_last: 5};
    vecs[3] = '{mode: 1, val: -7,       gap: 0, exp_count: 225, exp_last: RELU ? 0 : -7};
    vecs[4] = '{mode: 2, val: 0,        gap: 0, exp_count: 225, exp_last: RELU ? 0 : -869};
    vecs[5] = '{mode: 3, val: 0,        gap: 0, exp_count: 225, exp_last: 899};
    vecs[6] = '{mode: 1, val: -2097152, gap: 0, exp_count: 225, exp_last: RELU ? 0 : -2097152};
    vecs[7] = '{mode: 1, val: 2097151,  gap: 2, exp_count: 225, exp_last: 2097151};

    mon_en      = 1'b0;
    rst         = 1'b1;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    startMonitor(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset out_last", out_last, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Samples while idle must be dropped.
    applyStimulus(40, 0, 0, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("idle output count", mon_cnt, 0);

    for (int v = 0; v < 8; v++) begin
      startMonitor(vecs[v].mode, vecs[v].val, vecs[v].exp_count);
      pulseFrameStart(1'b0);
      checkOutput($sformatf("vec%0d busy after start", v), busy, 1);
      applyStimulus(W * H, vecs[v].mode, vecs[v].val, vecs[v].gap, 1'b1);
      repeat (4) begin @(posedge clk); #1; end
      checkOutput($sformatf("vec%0d output count", v), mon_cnt, vecs[v].exp_count);
      checkOutput($sformatf("vec%0d last value", v), last_data, vecs[v].exp_last);
      checkOutput($sformatf("vec%0d busy after frame", v), busy, 0);
      checkOutput($sformatf("vec%0d leftover latency entries", v), lat_q.size(), 0);
    end

    // Abort a partial frame with a frame_start that coincides with in_valid.
    startMonitor(0, 0, 225);
    pulseFrameStart(1'b0);
    applyStimulus(100, 0, 0, 0, 1'b1);
    pulseFrameStart(1'b1);
    checkOutput("abort partial outputs", mon_cnt, 20);
    checkOutput("abort busy", busy, 1);
    startMonitor(0, 0, 225);
    applyStimulus(W * H, 0, 0, 0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("restart output count", mon_cnt, 225);
    checkOutput("restart last value", last_data, 899);
    checkOutput("restart busy after frame", busy, 0);

    // Reset in the middle of a frame, then samples without frame_start.
    startMonitor(0, 0, 225);
    pulseFrameStart(1'b0);
    applyStimulus(500, 0, 0, 0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset out_data", out_data, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset outputs before reset", mon_cnt, 120);
    exp_total = mon_cnt;
    lat_q.delete();
    applyStimulus(400, 0, 0, 0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("post-reset output count", mon_cnt, 120);
    checkOutput("post-reset busy", busy, 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
